// File: rtl/fft_frame_serializer_pkg.sv
// Shared types for the FFT frame serializer: bin format, FFT size and read-FSM states.
package fft_frame_serializer_pkg;

  localparam int unsigned FFT_N = 8;
  localparam int unsigned CP_W  = 16;

  typedef struct packed {
    logic signed [CP_W-1:0] re;
    logic signed [CP_W-1:0] im;
  } complex_product_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/frame_pingpong_buffer.sv
// Two N-bin frame stores used as a 2-deep frame FIFO: whole-frame write, per-bin read.
module frame_pingpong_buffer
  import fft_frame_serializer_pkg::*;
#(
  parameter int unsigned N  = FFT_N,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  complex_product_t [N-1:0] i_wr_frame,
  input  logic                     i_free,
  input  logic                     i_rd_sel,
  input  logic [IW-1:0]            i_rd_idx,
  output complex_product_t         o_rd_data,
  output logic                     o_wr_ok,
  output logic [1:0]               o_full,
  output logic                     o_wr_ptr,
  output logic                     o_rd_ptr
);

  complex_product_t [N-1:0] r_mem [2];
  logic [1:0]               r_full;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic                     w_do_wr;

  // A full write buffer is still writable when it is the one being freed this cycle.
  assign o_wr_ok   = !r_full[r_wr_ptr] || (i_free && (r_rd_ptr == r_wr_ptr));
  assign w_do_wr   = i_wr_en && o_wr_ok;
  assign o_rd_data = r_mem[i_rd_sel][i_rd_idx];
  assign o_full    = r_full;
  assign o_wr_ptr  = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (i_free) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
      if (w_do_wr) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_frame;
    end
  end

endmodule

// File: rtl/fft_frame_serializer.sv
// Captures parallel FFT frames into a ping-pong store and streams them one bin per cycle.
module fft_frame_serializer
  import fft_frame_serializer_pkg::*;
#(
  parameter int unsigned N = FFT_N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  complex_product_t [N-1:0] in_frame,
  output complex_product_t         out_data,
  output logic [$clog2(N)-1:0]     out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     overflow,
  output logic [1:0]               frames_held
);

  localparam int unsigned IW = $clog2(N);

  ser_state_t       r_state;
  logic [IW-1:0]    r_rd_idx;
  complex_product_t r_out_data;
  logic             r_out_last;
  logic             r_overflow;

  complex_product_t w_rd_data;
  complex_product_t w_bin;
  logic             w_wr_ok;
  logic [1:0]       w_full;
  logic [1:0]       w_full_nxt;
  logic             w_wr_ptr;
  logic             w_rd_ptr;
  logic             w_rd_ptr_nxt;
  logic             w_hs;
  logic             w_last_hs;
  logic             w_wr;
  logic             w_rd_sel;
  logic [IW-1:0]    w_rd_idx;
  logic [IW-1:0]    w_idx_nxt;
  ser_state_t       w_state_nxt;
  logic             w_load;

  frame_pingpong_buffer #(
    .N  (N),
    .IW (IW)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (in_valid),
    .i_wr_frame (in_frame),
    .i_free     (w_last_hs),
    .i_rd_sel   (w_rd_sel),
    .i_rd_idx   (w_rd_idx),
    .o_rd_data  (w_rd_data),
    .o_wr_ok    (w_wr_ok),
    .o_full     (w_full),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr)
  );

  assign w_hs         = (r_state == ST_STREAM) && out_ready;
  assign w_last_hs    = w_hs && (r_rd_idx == IW'(N - 1));
  assign w_wr         = in_valid && w_wr_ok;
  assign w_rd_ptr_nxt = w_last_hs ? ~w_rd_ptr : w_rd_ptr;

  always_comb begin
    w_full_nxt = w_full;
    if (w_last_hs) w_full_nxt[w_rd_ptr] = 1'b0;
    if (w_wr)      w_full_nxt[w_wr_ptr] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_rd_idx;
    w_rd_sel    = w_rd_ptr;
    w_rd_idx    = '0;
    w_load      = 1'b0;
    if ((r_state == ST_STREAM) && !w_hs) begin
      w_state_nxt = ST_STREAM;
    end else if (w_hs && !w_last_hs) begin
      w_idx_nxt = r_rd_idx + 1'b1;
      w_rd_idx  = w_idx_nxt;
      w_load    = 1'b1;
    end else begin
      w_idx_nxt = '0;
      w_rd_sel  = w_rd_ptr_nxt;
      if (w_full_nxt[w_rd_ptr_nxt]) begin
        w_state_nxt = ST_STREAM;
        w_load      = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // A frame landing this cycle in the buffer about to be read is forwarded straight from in_frame,
  // which gives one-cycle capture latency and gapless frame-to-frame streaming.
  assign w_bin = (w_wr && (w_wr_ptr == w_rd_sel)) ? in_frame[w_rd_idx] : w_rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rd_idx   <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_idx <= w_idx_nxt;
      if (w_load) begin
        r_out_data <= w_bin;
        r_out_last <= (w_idx_nxt == IW'(N - 1));
      end else if (w_state_nxt == ST_IDLE) begin
        r_out_data <= '0;
        r_out_last <= 1'b0;
      end
      if (in_valid && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid   = (r_state == ST_STREAM);
  assign out_data    = r_out_data;
  assign out_index   = r_rd_idx;
  assign out_last    = r_out_last;
  assign overflow    = r_overflow;
  assign frames_held = {w_full[1] & w_full[0], w_full[1] ^ w_full[0]};

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomized and directed bench for fft_frame_serializer against a frame-queue reference model.
module tb_fft_frame_serializer;
  import fft_frame_serializer_pkg::*;

  localparam int unsigned N  = FFT_N;
  localparam int unsigned IW = $clog2(N);

  typedef complex_product_t [N-1:0] frame_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  frame_t           in_frame;
  complex_product_t out_data;
  logic [IW-1:0]    out_index;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             overflow;
  logic [1:0]       frames_held;

  fft_frame_serializer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_frame    (in_frame),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .overflow    (overflow),
    .frames_held (frames_held)
  );

  always #5 clk = ~clk;

  // Model: stored frames in arrival order, read position in the head frame, sticky drop flag.
  frame_t      m_q[$];
  int unsigned m_idx;
  bit          m_ovf;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit hs, last_hs, acc;
    hs      = (m_q.size() > 0) && out_ready;
    last_hs = hs && (m_idx == N - 1);
    acc     = in_valid && ((m_q.size() < 2) || last_hs);
    if (in_valid && !acc) m_ovf = 1'b1;
    if (hs) begin
      if (last_hs) begin
        void'(m_q.pop_front());
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (acc) m_q.push_back(in_frame);
  endtask

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("frames_held", 64'(frames_held), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(m_q[0][m_idx]));
      chk("out_index", 64'(out_index), 64'(m_idx));
      chk("out_last", 64'(out_last), 64'(m_idx == N - 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    in_valid = 1'b0;
  endtask

  task automatic send(input frame_t f);
    in_frame = f;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (m_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (m_q.size() > 0) chk("drain_timeout", 64'(m_q.size()), 64'd0);
  endtask

  task automatic wait_idx(input int unsigned idx);
    for (int i = 0; i < 40 && m_idx != idx; i++) tick();
    if (m_idx != idx) chk("wait_idx_timeout", 64'(m_idx), 64'(idx));
  endtask

  function automatic frame_t ramp(input int base, input bit neg_im);
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f[k].re = 16'(base + k);
      f[k].im = neg_im ? 16'(-k) : 16'(base + k);
    end
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f[k].re = 16'($urandom);
      f[k].im = 16'($urandom);
    end
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"},  64'(out_data),  64'd0);
    chk({tag, "_index"}, 64'(out_index), 64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_ovf"},   64'(overflow),  64'd0);
    chk({tag, "_held"},  64'(frames_held), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_frame  = '0;
    m_idx     = 0;
    m_ovf     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Single ramp frame, free-flowing
    out_ready = 1'b1;
    send(ramp(0, 1'b1));
    drain();
    tick();

    // Backpressure at index 3
    send(rand_frame());
    wait_idx(3);
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    drain();

    // Back-to-back frames, second pulsed 4 cycles after the first
    send(ramp(16'h10, 1'b0));
    repeat (3) tick();
    send(ramp(16'h20, 1'b0));
    drain();

    // Coincident free: third frame arrives on frame 1's last handshake
    out_ready = 1'b0;
    send(rand_frame());
    send(rand_frame());
    tick();
    out_ready = 1'b1;
    wait_idx(N - 1);
    send(rand_frame());
    chk("coincident_no_ovf", 64'(overflow), 64'd0);
    drain();

    // Overflow: three frames into a stalled output
    out_ready = 1'b0;
    send(rand_frame());
    send(rand_frame());
    send(rand_frame());
    chk("ovf_set", 64'(overflow), 64'd1);
    repeat (3) tick();
    out_ready = 1'b1;
    drain();
    tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        in_frame = rand_frame();
        in_valid = 1'b1;
      end
      tick();
    end
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream at index 4
    send(rand_frame());
    wait_idx(4);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    m_q.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    compare();
    send(ramp(3, 1'b1));
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Sits directly downstream of the 8-point radix-2 FFT.
- Captures each parallel N-point FFT result frame, presented as an N-element complex_product_t array with a one-cycle valid pulse.
- Streams the frame out one bin per cycle in natural order (bin 0 first) over a valid/ready handshake.
- Double-buffered (ping-pong), so a new frame can be captured while the previous one drains. Frames that cannot be stored are dropped and flagged.

Parameters:
- N, 8, FFT size and bins per frame; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  one-cycle pulse: in_frame holds a complete frame this cycle.
- in_frame  input  complex_product_t [N-1:0]  frame bins; element k is bin k.
- out_data  output  complex_product_t  current bin.
- out_index  output  $clog2(N)  bin number of out_data.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
- out_last  output  1  high with bin N-1 of a frame.
- overflow  output  1  sticky: at least one frame was dropped.
- frames_held  output  2  number of frames stored (0..2), including the one draining.

Behaviour:
- Reset (async assert, sync release) values:
  - out_valid=0, out_data='0, out_index=0, out_last=0, overflow=0, frames_held=0.
  - Read and write buffer pointers = 0; both buffers marked empty. Buffer contents are don't-care.
- Storage: two N-entry frame buffers used as a 2-deep frame FIFO. Write pointer and read pointer each toggle per frame. Frame order is preserved.
- Capture: when in_valid=1 and a buffer is free, all N bins are copied into the write buffer in one cycle. That buffer becomes full and the write pointer toggles.
- Read FSM has two states:
  - IDLE: out_valid=0. Moves to STREAM on the cycle after a buffer becomes full. rd_idx=0.
  - STREAM: out_valid=1, out_data=buf[rd].bin[rd_idx], out_index=rd_idx, out_last=(rd_idx==N-1).
    - On a handshake with rd_idx<N-1: rd_idx increments.
    - On a handshake with rd_idx=N-1: the buffer is freed, the read pointer toggles and rd_idx=0. The FSM stays in STREAM if the other buffer is full, otherwise goes to IDLE.
- Outputs are registered. Latency from in_valid (empty block) to first out_valid = 1 cycle.
- With out_ready held high, back-to-back frames stream with no bubble between bin N-1 and the next frame's bin 0.
- Stall rule: while out_valid=1 and out_ready=0, out_data/out_index/out_last hold stable.
- Full rule: in_valid with frames_held=2 drops the frame and sets overflow.
  - Exception: if the same cycle completes the last-beat handshake, the freed buffer is written and nothing is dropped.
- Simultaneous capture and last-beat handshake with frames_held=1: the capture goes to the other buffer. frames_held stays 1 and streaming continues without a gap.
- frames_held updates as +1 on capture, -1 on last-beat handshake, and both in the same cycle give net 0.
- overflow clears only on reset.
- Reset mid-frame: all frames are discarded and outputs return to reset values immediately (asynchronously).
- No arithmetic on data: bins pass through bit-exact with no width change.

Decomposition:
- Shared package:
  - complex_product_t, reused as-is.
  - FFT_N=8 localparam.
  - Serializer state enum (IDLE, STREAM).
- One natural sub-module: frame_pingpong_buffer.
  - Holds the two frame stores, the write/read pointers and full flags.
  - Interface: write-whole-frame port, per-bin read port (buffer select, index), free/full status.
- fft_frame_serializer keeps the read FSM, rd_idx, the output registers and overflow.

Test Plan:
- Single frame, bins k = {re=k, im=-k}, out_ready=1 → out_valid rises 1 cycle after in_valid; 8 consecutive beats with indices 0..7 and matching data; out_last only on index 7; frames_held 1→0; out_valid=0 afterwards.
- Backpressure: out_ready=0 for 5 cycles at index 3 → index 3 data held stable; streaming resumes at 3 with no loss or duplication.
- Back-to-back: frame A (bins 0x10+k), then frame B (0x20+k) pulsed 4 cycles later, out_ready=1 → 16 gapless beats, A then B; frames_held peaks at 2.
- Overflow: out_ready=0, three in_valid pulses → frames 1 and 2 stored, third dropped; overflow=1, frames_held=2. Release out_ready → only frames 1 and 2 emerge; overflow stays 1.
- Coincident free: frames_held=2, in_valid in the same cycle as frame 1's index-7 handshake → no overflow, frames_held stays 2, the third frame streams after frame 2.
- Reset mid-stream at index 4 (asynchronous, between clock edges) → outputs zero immediately; after release, a new frame streams from index 0 with overflow=0.
